// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared constants and state type for the sequential divider
package calc_pkg;
  localparam int WIDTH = 24;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;
endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring shift-subtract step of the divider
module div_step
  import calc_pkg::*;
(
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);
  logic [WIDTH:0] partial;
  logic [WIDTH:0] diff;

  // The shifted remainder needs the full W+1 bits: divisors above 2^(W-1) would otherwise lose rem's MSB.
  always_comb begin
    partial  = {rem, dvd_msb};
    diff     = partial - {1'b0, divisor};
    q_bit    = ~diff[WIDTH];
    next_rem = q_bit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
  end
endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative restoring divider, one quotient bit per clock
// SIGNED_DIV_EN selects two's-complement operands with truncation toward zero.
module seq_divider
  import calc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  div_state_t       state, state_nxt;
  logic [WIDTH-1:0] dvd_q, rem_q, quo_q, dsr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             zero_pend;
  logic             accept;
  logic             divisor_zero;
  logic [WIDTH-1:0] dvd_in, dsr_in;
  logic [WIDTH-1:0] next_rem;
  logic             q_bit;
  logic [WIDTH-1:0] q_raw, q_fin, r_fin;

`ifdef SIGNED_DIV_EN
  logic neg_q, neg_r;

  always_comb begin
    dsr_in = divisor[WIDTH-1] ? -divisor : divisor;
    dvd_in = divisor_zero ? dividend : (dividend[WIDTH-1] ? -dividend : dividend);
    q_fin  = neg_q ? -q_raw : q_raw;
    r_fin  = neg_r ? -next_rem : next_rem;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r <= dividend[WIDTH-1];
    end
  end
`else
  always_comb begin
    dsr_in = divisor;
    dvd_in = dividend;
    q_fin  = q_raw;
    r_fin  = next_rem;
  end
`endif

  div_step u_step (
    .rem      (rem_q),
    .dvd_msb  (dvd_q[WIDTH-1]),
    .divisor  (dsr_q),
    .next_rem (next_rem),
    .q_bit    (q_bit)
  );

  assign divisor_zero = (divisor == '0);
  assign q_raw        = {quo_q[WIDTH-2:0], q_bit};
  assign busy         = (state == RUN);
  assign done         = (state == DONE);

  // Divide-by-zero parks one cycle in IDLE with zero_pend so its done lands one edge after the start edge.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (zero_pend) begin
          state_nxt = DONE;
        end else if (start) begin
          accept    = 1'b1;
          state_nxt = divisor_zero ? IDLE : RUN;
        end
      end
      RUN: begin
        if (cnt_q == '0) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = divisor_zero ? IDLE : RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      dvd_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dsr_q       <= '0;
      cnt_q       <= '0;
      zero_pend   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        dvd_q       <= dvd_in;
        dsr_q       <= dsr_in;
        rem_q       <= '0;
        quo_q       <= '0;
        cnt_q       <= CNT_W'(WIDTH - 1);
        zero_pend   <= divisor_zero;
        div_by_zero <= 1'b0;
      end
      if (state == RUN) begin
        dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
        rem_q <= next_rem;
        quo_q <= q_raw;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == '0) begin
          quotient  <= q_fin;
          remainder <= r_fin;
        end
      end
      if (state == IDLE && zero_pend) begin
        zero_pend   <= 1'b0;
        quotient    <= '1;
        remainder   <= dvd_q;
        div_by_zero <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed self-checking bench for seq_divider
module tb_seq_divider;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [23:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [23:0] quotient, remainder;

  int passed = 0;
  int total  = 0;

  seq_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Pulses start for one edge, then waits (bounded) for done; lat counts edges after the start edge.
  task automatic launch(input logic [23:0] a, input logic [23:0] b,
                        output int lat, output bit busy_seen, output bit overlap);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    lat       = 0;
    busy_seen = busy;
    overlap   = busy & done;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
      busy_seen = busy_seen | busy;
      overlap   = overlap | (busy & done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    dividend = 24'd0;
    divisor  = 24'd0;
    @(negedge clk);
    @(negedge clk);
    total += 5;
    if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else passed++;
    if (done !== 1'b0) $display("FAIL reset_done got %0b want 0", done); else passed++;
    if (div_by_zero !== 1'b0) $display("FAIL reset_dz got %0b want 0", div_by_zero); else passed++;
    if (quotient !== 24'd0) $display("FAIL reset_q got %h want 000000", quotient); else passed++;
    if (remainder !== 24'd0) $display("FAIL reset_r got %h want 000000", remainder); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat; bit bs, ov;
    launch(24'd100, 24'd7, lat, bs, ov);
    total += 7;
    if (lat !== 24) $display("FAIL basic_lat got %0d want 24", lat); else passed++;
    if (quotient !== 24'd14) $display("FAIL basic_q got %0d want 14", quotient); else passed++;
    if (remainder !== 24'd2) $display("FAIL basic_r got %0d want 2", remainder); else passed++;
    if (div_by_zero !== 1'b0) $display("FAIL basic_dz got %0b want 0", div_by_zero); else passed++;
    if (bs !== 1'b1) $display("FAIL basic_busy got %0b want 1", bs); else passed++;
    if (ov !== 1'b0) $display("FAIL basic_overlap got %0b want 0", ov); else passed++;
    @(negedge clk);
    if (done !== 1'b0) $display("FAIL basic_done_pulse got %0b want 0", done); else passed++;
  endtask

  task automatic test_identity();
    int lat; bit bs, ov;
    launch(24'hFFFFFF, 24'd1, lat, bs, ov);
    total += 3;
    if (lat !== 24) $display("FAIL id_lat got %0d want 24", lat); else passed++;
    if (quotient !== 24'hFFFFFF) $display("FAIL id_q got %h want ffffff", quotient); else passed++;
    if (remainder !== 24'd0) $display("FAIL id_r got %h want 000000", remainder); else passed++;
    launch(24'd5, 24'd9, lat, bs, ov);
    total += 2;
    if (quotient !== 24'd0) $display("FAIL small_q got %h want 000000", quotient); else passed++;
    if (remainder !== 24'd5) $display("FAIL small_r got %h want 000005", remainder); else passed++;
    launch(24'd0, 24'd5, lat, bs, ov);
    total += 2;
    if (quotient !== 24'd0) $display("FAIL zero_num_q got %h want 000000", quotient); else passed++;
    if (remainder !== 24'd0) $display("FAIL zero_num_r got %h want 000000", remainder); else passed++;
    launch(24'hFFFFFF, 24'h800001, lat, bs, ov);
    total += 2;
    if (quotient !== 24'd1) $display("FAIL big_dsr_q got %h want 000001", quotient); else passed++;
    if (remainder !== 24'h7FFFFE) $display("FAIL big_dsr_r got %h want 7ffffe", remainder); else passed++;
  endtask

  task automatic test_div_zero();
    int lat; bit bs, ov;
    launch(24'd5, 24'd0, lat, bs, ov);
    total += 5;
    if (lat !== 1) $display("FAIL dz_lat got %0d want 1", lat); else passed++;
    if (quotient !== 24'hFFFFFF) $display("FAIL dz_q got %h want ffffff", quotient); else passed++;
    if (remainder !== 24'd5) $display("FAIL dz_r got %h want 000005", remainder); else passed++;
    if (div_by_zero !== 1'b1) $display("FAIL dz_flag got %0b want 1", div_by_zero); else passed++;
    if (bs !== 1'b0) $display("FAIL dz_busy got %0b want 0", bs); else passed++;
  endtask

  task automatic test_back_to_back();
    int lat; bit bs, ov;
    launch(24'd7, 24'd0, lat, bs, ov);
    // Still in the done cycle: start again straight from DONE.
    dividend = 24'd100;
    divisor  = 24'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    total += 4;
    if (lat !== 24) $display("FAIL b2b_lat got %0d want 24", lat); else passed++;
    if (quotient !== 24'd14) $display("FAIL b2b_q got %0d want 14", quotient); else passed++;
    if (remainder !== 24'd2) $display("FAIL b2b_r got %0d want 2", remainder); else passed++;
    if (div_by_zero !== 1'b0) $display("FAIL b2b_dz got %0b want 0", div_by_zero); else passed++;
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    dividend = 24'd1000;
    divisor  = 24'd10;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == 4) begin
        dividend = 24'd7;
        divisor  = 24'd7;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    total += 3;
    if (lat !== 24) $display("FAIL ign_lat got %0d want 24", lat); else passed++;
    if (quotient !== 24'd100) $display("FAIL ign_q got %0d want 100", quotient); else passed++;
    if (remainder !== 24'd0) $display("FAIL ign_r got %0d want 0", remainder); else passed++;
  endtask

  task automatic test_reset_abort();
    int lat; bit bs, ov; bit done_seen;
    @(negedge clk);
    dividend = 24'd100;
    divisor  = 24'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total += 4;
    if (busy !== 1'b0) $display("FAIL abort_busy got %0b want 0", busy); else passed++;
    if (quotient !== 24'd0) $display("FAIL abort_q got %h want 000000", quotient); else passed++;
    if (remainder !== 24'd0) $display("FAIL abort_r got %h want 000000", remainder); else passed++;
    done_seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      done_seen = done_seen | done;
    end
    if (done_seen !== 1'b0) $display("FAIL abort_no_done got %0b want 0", done_seen); else passed++;
    launch(24'd9, 24'd3, lat, bs, ov);
    total += 3;
    if (lat !== 24) $display("FAIL after_abort_lat got %0d want 24", lat); else passed++;
    if (quotient !== 24'd3) $display("FAIL after_abort_q got %0d want 3", quotient); else passed++;
    if (remainder !== 24'd0) $display("FAIL after_abort_r got %0d want 0", remainder); else passed++;
  endtask

  task automatic test_sign_mode();
    int lat; bit bs, ov;
`ifdef SIGNED_DIV_EN
    launch(24'hFFFFF9, 24'h000002, lat, bs, ov);
    total += 2;
    if (quotient !== 24'hFFFFFD) $display("FAIL sgn_q got %h want fffffd", quotient); else passed++;
    if (remainder !== 24'hFFFFFF) $display("FAIL sgn_r got %h want ffffff", remainder); else passed++;
    launch(24'h800000, 24'hFFFFFF, lat, bs, ov);
    total += 2;
    if (quotient !== 24'h800000) $display("FAIL sgn_min_q got %h want 800000", quotient); else passed++;
    if (remainder !== 24'h000000) $display("FAIL sgn_min_r got %h want 000000", remainder); else passed++;
`else
    launch(24'hFFFFF9, 24'h000002, lat, bs, ov);
    total += 2;
    if (quotient !== 24'h7FFFFC) $display("FAIL uns_q got %h want 7ffffc", quotient); else passed++;
    if (remainder !== 24'h000001) $display("FAIL uns_r got %h want 000001", remainder); else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_identity();
    test_div_zero();
    test_back_to_back();
    test_ignore_start();
    test_reset_abort();
    test_sign_mode();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
